fp_result_collector: RTL

- Downstream stage of the floatingpoint add/mul unit: samples its result32/result64/overflow outputs whenever an operation is tagged valid, classifies the IEEE-754 result and buffers it in a small FIFO.
- The buffer drains over a valid/ready interface to the consumer (host readback / scoreboard).
- The floatingpoint unit cannot stall, so the collector never back-pressures it. Results arriving into a full buffer are dropped and counted.

---
 rtl/fp_pkg.sv | 55 +++++
 rtl/fp_classify.sv | 47 ++++
 rtl/fp_result_collector.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/fp_pkg.sv
// Shared definitions for the floating-point result path.
// Holds the mode/op encodings, the IEEE-754 class encoding, the field widths
// for single and double precision, the buffered-entry layout and a helper
// that turns exponent/fraction flags into a class.
package fp_pkg;

  localparam logic SINGLE = 1'b0;
  localparam logic DOUBLE = 1'b1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ADD  = 2'd1;
  localparam logic [1:0] MUL  = 2'd2;

  typedef enum logic [2:0] {
    CLS_ZERO    = 3'd0,
    CLS_SUBNORM = 3'd1,
    CLS_NORMAL  = 3'd2,
    CLS_INF     = 3'd3,
    CLS_QNAN    = 3'd4,
    CLS_SNAN    = 3'd5
  } fp_class_e;

  localparam int SP_EXP_W  = 8;
  localparam int SP_FRAC_W = 23;
  localparam int DP_EXP_W  = 11;
  localparam int DP_FRAC_W = 52;

  // One buffered result: payload plus everything the consumer sees with it.
  typedef struct packed {
    logic [63:0] data;
    logic        mode;
    logic [1:0]  op;
    fp_class_e   cls;
    logic        sign;
    logic        ovf;
  } fp_entry_t;

  // Precision-independent classification from the exponent/fraction flags.
  function automatic fp_class_e classify_fields(input logic exp_zero,
                                                input logic exp_ones,
                                                input logic frac_zero,
                                                input logic frac_msb);
    fp_class_e c;
    c = CLS_NORMAL;
    if (exp_zero) begin
      c = frac_zero ? CLS_ZERO : CLS_SUBNORM;
    end else if (exp_ones) begin
      if (frac_zero)     c = CLS_INF;
      else if (frac_msb) c = CLS_QNAN;
      else               c = CLS_SNAN;
    end
    return c;
  endfunction

endpackage

// File: rtl/fp_classify.sv
// Combinational IEEE-754 classifier.
// Ports:
//   mode  - 0: single, value[31:0] is the operand; 1: double, all 64 bits
//   value - operand bits (upper half ignored in single mode)
//   cls   - 0=zero 1=subnormal 2=normal 3=inf 4=qNaN 5=sNaN
//   sign  - sign bit of the selected precision
module fp_classify
  import fp_pkg::*;
(
  input  logic        mode,
  input  logic [63:0] value,
  output logic [2:0]  cls,
  output logic        sign
);

  logic [SP_EXP_W-1:0]  sp_exp;
  logic [SP_FRAC_W-1:0] sp_frac;
  logic [DP_EXP_W-1:0]  dp_exp;
  logic [DP_FRAC_W-1:0] dp_frac;
  logic                 exp_zero;
  logic                 exp_ones;
  logic                 frac_zero;
  logic                 frac_msb;

  assign sp_exp  = value[30:23];
  assign sp_frac = value[22:0];
  assign dp_exp  = value[62:52];
  assign dp_frac = value[51:0];

  always_comb begin
    if (mode == DOUBLE) begin
      exp_zero  = (dp_exp == '0);
      exp_ones  = (dp_exp == '1);
      frac_zero = (dp_frac == '0);
      frac_msb  = dp_frac[DP_FRAC_W-1];
      sign      = value[63];
    end else begin
      exp_zero  = (sp_exp == '0);
      exp_ones  = (sp_exp == '1);
      frac_zero = (sp_frac == '0);
      frac_msb  = sp_frac[SP_FRAC_W-1];
      sign      = value[31];
    end
    cls = classify_fields(exp_zero, exp_ones, frac_zero, frac_msb);
  end

endmodule

// File: rtl/fp_result_collector.sv
// Collects results of the floating-point add/mul unit into a small FIFO.
// Every valid ADD/MUL result is classified at capture time and stored with
// its mode, op, sign and overflow flag. The producer can never be stalled:
// a result arriving at a full buffer (with no pop that cycle) is dropped and
// counted. The head entry is presented first-word-fall-through.
// Ports:
//   clk, rst              - clock, synchronous active-high reset
//   in_valid/in_mode/in_op, result32/result64/overflow - producer side
//   out_valid/out_ready   - consumer handshake
//   out_data/mode/op/class/sign/ovf - head entry, all zero while empty
//   level                 - occupancy
//   ovf_count/drop_count  - saturating event counters
module fp_result_collector
  import fp_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic                     in_mode,
  input  logic [1:0]               in_op,
  input  logic [31:0]              result32,
  input  logic [63:0]              result64,
  input  logic                     overflow,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [63:0]              out_data,
  output logic                     out_mode,
  output logic [1:0]               out_op,
  output logic [2:0]               out_class,
  output logic                     out_sign,
  output logic                     out_ovf,
  output logic [$clog2(DEPTH):0]   level,
  output logic [CNT_W-1:0]         ovf_count,
  output logic [CNT_W-1:0]         drop_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]      FULL_LVL = DEPTH[AW:0];
  localparam logic [AW:0]      LVL_ONE  = {{AW{1'b0}}, 1'b1};
  localparam logic [AW-1:0]    PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_ONE;
  endfunction

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      level_q, level_d;
  logic [CNT_W-1:0] ovf_cnt_q, ovf_cnt_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

  // Storage carries data only; validity is defined by the pointers/level.
  fp_entry_t        mem_q [DEPTH];

  logic             push_req;
  logic             pop;
  logic             push_acc;
  logic             wr_en;
  logic [63:0]      cls_value;
  logic [2:0]       new_cls;
  logic             new_sign;
  fp_entry_t        new_entry;
  fp_entry_t        head;

  // Single results are zero-extended so the stored word is the same value
  // the classifier saw; the unused result bus is ignored entirely.
  assign cls_value = (in_mode == DOUBLE) ? result64 : {32'h0, result32};

  fp_classify u_classify (
    .mode  (in_mode),
    .value (cls_value),
    .cls   (new_cls),
    .sign  (new_sign)
  );

  always_comb begin
    new_entry      = '0;
    new_entry.data = cls_value;
    new_entry.mode = in_mode;
    new_entry.op   = in_op;
    new_entry.cls  = fp_class_e'(new_cls);
    new_entry.sign = new_sign;
    new_entry.ovf  = overflow;
  end

  always_comb begin
    out_valid = (level_q != '0);
    push_req  = in_valid && ((in_op == ADD) || (in_op == MUL));
    pop       = out_valid && out_ready;
    // A full buffer still accepts when the head leaves in the same cycle.
    push_acc  = push_req && ((level_q < FULL_LVL) || pop);
    wr_en     = push_acc && !rst;

    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    ovf_cnt_d  = ovf_cnt_q;
    drop_cnt_d = drop_cnt_q;

    if (push_acc) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (overflow) ovf_cnt_d = sat_inc(ovf_cnt_q);
    end else if (push_req) begin
      drop_cnt_d = sat_inc(drop_cnt_q);
    end

    if (pop) rd_ptr_d = rd_ptr_q + PTR_ONE;

    case ({push_acc, pop})
      2'b10:   level_d = level_q + LVL_ONE;
      2'b01:   level_d = level_q - LVL_ONE;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      ovf_cnt_q  <= '0;
      drop_cnt_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      ovf_cnt_q  <= ovf_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= new_entry;
  end

  // Head fields are forced to zero while empty so stale storage never leaks.
  always_comb begin
    head       = out_valid ? mem_q[rd_ptr_q] : '0;
    out_data   = head.data;
    out_mode   = head.mode;
    out_op     = head.op;
    out_class  = head.cls;
    out_sign   = head.sign;
    out_ovf    = head.ovf;
  end

  assign level      = level_q;
  assign ovf_count  = ovf_cnt_q;
  assign drop_count = drop_cnt_q;

endmodule
